// File: rtl/plru_pkg.sv
// Shared tree-PLRU definitions: per-set state type, one-hot way constants,
// the touch update rule and the tree victim selection.
// State bits: s[0]=1 -> left pair (ways 0/1) is older, s[1]=1 -> way0 older,
// s[2]=1 -> way2 older.
package plru_pkg;

  typedef logic [2:0] plru_state_t;
  typedef logic [3:0] plru_way_t;

  localparam plru_way_t WAY0 = 4'b0001;
  localparam plru_way_t WAY1 = 4'b0010;
  localparam plru_way_t WAY2 = 4'b0100;
  localparam plru_way_t WAY3 = 4'b1000;

  typedef enum logic [0:0] {StIdle, StHold} resp_state_e;

  // Point every node on the touched way's path away from it.
  function automatic plru_state_t plru_touch(input plru_state_t s, input plru_way_t way);
    plru_state_t n;
    case (way)
      WAY0:    n = {s[2], 2'b00};
      WAY1:    n = {s[2], 2'b10};
      WAY2:    n = {1'b0, s[1], 1'b1};
      WAY3:    n = {1'b1, s[1], 1'b1};
      default: n = s;
    endcase
    return n;
  endfunction

  function automatic plru_way_t plru_victim(input plru_state_t s);
    plru_way_t v;
    if (s[0]) v = s[1] ? WAY0 : WAY1;
    else      v = s[2] ? WAY2 : WAY3;
    return v;
  endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational tree-PLRU logic for one touch and one query.
//   touch_state/touch_valid/touch_way -> touch_next, touch_apply
//     touch_apply is low for a malformed (not one-hot) way.
//   query_state/valid_ways -> victim (one-hot)
//     the lowest-index invalid way wins over the tree choice.
// With NUM_WAYS=2, way0/way1 map onto tree way0/way2 and only s[0] picks.
module plru_tree_logic
  import plru_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4
) (
  input  plru_state_t          touch_state,
  input  logic                 touch_valid,
  input  logic [NUM_WAYS-1:0]  touch_way,
  output plru_state_t          touch_next,
  output logic                 touch_apply,
  input  plru_state_t          query_state,
  input  logic [NUM_WAYS-1:0]  valid_ways,
  output logic [NUM_WAYS-1:0]  victim
);

  plru_way_t            tree_way;
  logic [NUM_WAYS-1:0]  tree_victim;

  if (NUM_WAYS == 4) begin : g_four
    assign tree_way    = touch_way;
    assign tree_victim = plru_victim(query_state);
  end else begin : g_two
    assign tree_way    = {1'b0, touch_way[1], 1'b0, touch_way[0]};
    assign tree_victim = query_state[0] ? 2'b01 : 2'b10;
  end

  assign touch_apply = touch_valid && ($countones(touch_way) == 1);
  assign touch_next  = plru_touch(touch_state, tree_way);

  always_comb begin
    logic found;
    found  = 1'b0;
    victim = tree_victim;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (!found && !valid_ways[i]) begin
        found     = 1'b1;
        victim    = '0;
        victim[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plru_state_ctrl.sv
// Per-set tree-PLRU state owner with victim query/response handshake.
//   clk, rst (async, active high)
//   touch_valid/touch_index/touch_way : hit/fill touch, applied at the edge
//   vq_valid/vq_ready/vq_index/vq_valid_ways : victim query
//   vr_valid/vr_ready/vr_way : registered victim response, held until taken
module plru_state_ctrl
  import plru_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = 4,
  parameter  int unsigned NUM_SETS = 8,
  localparam int unsigned IDX_W    = $clog2(NUM_SETS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 touch_valid,
  input  logic [IDX_W-1:0]     touch_index,
  input  logic [NUM_WAYS-1:0]  touch_way,
  input  logic                 vq_valid,
  output logic                 vq_ready,
  input  logic [IDX_W-1:0]     vq_index,
  input  logic [NUM_WAYS-1:0]  vq_valid_ways,
  output logic                 vr_valid,
  input  logic                 vr_ready,
  output logic [NUM_WAYS-1:0]  vr_way
);

  plru_state_t          state_q [NUM_SETS];
  plru_state_t          touch_next;
  plru_state_t          query_state;
  logic                 touch_apply;
  logic [NUM_WAYS-1:0]  victim;
  logic                 handshake;

  resp_state_e          resp_q, resp_d;
  logic [NUM_WAYS-1:0]  vr_way_q, vr_way_d;

  // A same-cycle touch to the queried set is forwarded into the query.
  assign query_state = (touch_apply && (touch_index == vq_index)) ? touch_next
                                                                  : state_q[vq_index];

  plru_tree_logic #(
    .NUM_WAYS (NUM_WAYS)
  ) u_tree (
    .touch_state (state_q[touch_index]),
    .touch_valid (touch_valid),
    .touch_way   (touch_way),
    .touch_next  (touch_next),
    .touch_apply (touch_apply),
    .query_state (query_state),
    .valid_ways  (vq_valid_ways),
    .victim      (victim)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '{default: '0};
    end else if (touch_apply) begin
      state_q[touch_index] <= touch_next;
    end
  end

  assign vr_valid  = (resp_q == StHold);
  assign vq_ready  = !vr_valid || vr_ready;
  assign handshake = vq_valid && vq_ready;
  assign vr_way    = vr_way_q;

  always_comb begin
    resp_d   = resp_q;
    vr_way_d = vr_way_q;
    unique case (resp_q)
      StIdle: begin
        if (handshake) begin
          resp_d   = StHold;
          vr_way_d = victim;
        end
      end
      StHold: begin
        // A new handshake implies vr_ready: replace the response in place.
        if (handshake)     vr_way_d = victim;
        else if (vr_ready) resp_d   = StIdle;
      end
      default: resp_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q   <= StIdle;
      vr_way_q <= '0;
    end else begin
      resp_q   <= resp_d;
      vr_way_q <= vr_way_d;
    end
  end

endmodule
